// File: rtl/seq_alu_md.sv
// seq_alu_md: handshaked ALU with registered result/flags and an iterative radix-2 MUL/DIV unit.
// Define SEQ_ALU_SIGNED_DIV_EN to add signed DIV (1110) / REM (1111); otherwise those codes act as ADD.
module seq_alu_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags,
  output logic            busy
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MULDIV = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
`ifdef SEQ_ALU_SIGNED_DIV_EN
  localparam logic [3:0]      OP_DIV  = 4'b1110;
  localparam logic [3:0]      OP_REM  = 4'b1111;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
`endif

  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(XLEN - 1);

  logic [1:0]        state;
  logic [2*XLEN-1:0] acc;   // MUL: {partial product, multiplier}; DIV: {remainder, dividend}
  logic [XLEN-1:0]   dvs;
  logic [SHW:0]      cnt;
  logic              md_div, md_hi;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_MULDIV);

  // Single-cycle datapath
  logic [XLEN:0]   add_w, sub_w;
  logic [XLEN-1:0] alu_res;
  logic            alu_c, alu_v;
  logic [SHW-1:0]  shamt;

  assign shamt = b[SHW-1:0];
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_SUB: begin
        alu_res = sub_w[XLEN-1:0];
        alu_c   = ~sub_w[XLEN];
        alu_v   = (a[XLEN-1] != b[XLEN-1]) && (sub_w[XLEN-1] != a[XLEN-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: begin  // ADD, and every code not decoded above
        alu_res = add_w[XLEN-1:0];
        alu_c   = add_w[XLEN];
        alu_v   = (a[XLEN-1] == b[XLEN-1]) && (add_w[XLEN-1] != a[XLEN-1]);
      end
    endcase
  end

  // MUL/DIV launch decode; op[1] selects divide, op[0] selects the upper half (MULHU/REM)
  logic            md_op, md_fast;
  logic [XLEN-1:0] md_a, md_b, md_fast_res;
`ifdef SEQ_ALU_SIGNED_DIV_EN
  logic            md_neg, neg_res;
`endif

  always_comb begin
    md_op       = (op[3:2] == 2'b10);
    md_a        = a;
    md_b        = b;
    md_fast     = md_op && op[1] && (b == '0);
    md_fast_res = op[0] ? a : '1;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    md_neg = 1'b0;
    if (op == OP_DIV || op == OP_REM) begin
      md_op  = 1'b1;
      md_neg = op[0] ? a[XLEN-1] : (a[XLEN-1] ^ b[XLEN-1]);
      md_a   = a[XLEN-1] ? -a : a;
      md_b   = b[XLEN-1] ? -b : b;
      if (b == '0) begin
        md_fast     = 1'b1;
        md_fast_res = op[0] ? a : '1;
      end else if (a == INT_MIN && b == '1) begin
        md_fast     = 1'b1;
        md_fast_res = op[0] ? '0 : a;
      end
    end
`endif
  end

  // One radix-2 step: shift-add for MUL, restoring subtract for DIV
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   md_raw, md_final;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, dvs} : '0);
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, dvs};
  assign acc_next  = !md_div      ? {mul_sum, acc[XLEN-1:1]} :
                     div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                                      {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
  assign md_raw    = md_hi ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
`ifdef SEQ_ALU_SIGNED_DIV_EN
  assign md_final  = neg_res ? -md_raw : md_raw;
`else
  assign md_final  = md_raw;
`endif

  function automatic logic [3:0] nz_flags(input logic [XLEN-1:0] r);
    return {r[XLEN-1], r == '0, 2'b00};
  endfunction

  // NOTE: every register here is updated with <= so all of them sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      result <= '0;
      flags  <= '0;
      acc    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      md_div <= 1'b0;
      md_hi  <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
      neg_res <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          if (md_op && !md_fast) begin
            state  <= ST_MULDIV;
            acc    <= op[1] ? {{XLEN{1'b0}}, md_a} : {{XLEN{1'b0}}, md_b};
            dvs    <= op[1] ? md_b : md_a;
            cnt    <= '0;
            md_div <= op[1];
            md_hi  <= op[0];
`ifdef SEQ_ALU_SIGNED_DIV_EN
            neg_res <= md_neg;
`endif
          end else if (md_op) begin
            state  <= ST_DONE;
            result <= md_fast_res;
            flags  <= nz_flags(md_fast_res);
          end else begin
            state  <= ST_DONE;
            result <= alu_res;
            flags  <= {alu_res[XLEN-1], alu_res == '0, alu_c, alu_v};
          end
        end
        ST_MULDIV: begin
          acc <= acc_next;
          cnt <= cnt + (SHW+1)'(1);
          if (cnt == CNT_LAST) begin
            state  <= ST_DONE;
            result <= md_final;
            flags  <= nz_flags(md_final);
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
